// File: rtl/dmem_bus_master_pkg.sv
// Shared types and constants for the data-memory/IO bus master.
package dmem_bus_master_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] IO_SW_ADDR   = 16'hfff0;
  localparam logic [ADDR_W-1:0] IO_DISP_ADDR = 16'hfffa;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEC_OK_RAM = 2'd0,
    DEC_OK_SW  = 2'd1,
    DEC_OK_DSP = 2'd2,
    DEC_ERR    = 2'd3
  } decode_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Map a request onto RAM, the switch port, the display port, or an error.
  function automatic decode_e decode_req(input logic              write,
                                         input logic [ADDR_W-1:0] addr,
                                         input int unsigned       mem_words,
                                         input logic [ADDR_W-1:0] io_sw,
                                         input logic [ADDR_W-1:0] io_disp);
    decode_e dec;
    if (32'(addr) < mem_words)          dec = DEC_OK_RAM;
    else if (addr == io_sw && !write)   dec = DEC_OK_SW;
    else if (addr == io_disp && write)  dec = DEC_OK_DSP;
    else                                dec = DEC_ERR;
    return dec;
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// Request FIFO: DEPTH entries of {write, addr, wdata}, head visible combinationally.
module dmem_req_fifo
  import dmem_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  req_t                   push_data,
  input  logic                   pop,
  output req_t                   head,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_pop  = pop & ~empty_c;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full_c | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_bus_master.sv
// Initiator on the data-memory/IO bus: queues load/store requests, runs one
// bus cycle per request and returns an in-order response pulse.
module dmem_bus_master
  import dmem_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 128,
  parameter logic [15:0] IO_SW     = IO_SW_ADDR,
  parameter logic [15:0] IO_DISP   = IO_DISP_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        dm_write,
  output logic        dm_read,
  input  logic [15:0] dm_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  req_t             push_req;
  req_t             head_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  decode_e          head_dec;
  state_e           state;
  logic             cur_write;

  assign push_req  = {req_write, req_addr, req_wdata};
  assign req_ready = (fifo_count != CNT_W'(DEPTH));
  assign push      = req_valid & ~fifo_full;
  assign pop       = (state == S_IDLE) & ~fifo_empty;

  always_comb begin
    head_dec = decode_req(head_req.write, head_req.addr, MEM_WORDS, IO_SW, IO_DISP);
  end

  dmem_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head_req),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count     (fifo_count)
  );

  // Bus FSM: strobes and response fields are pulses, cleared every cycle by default.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_write <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      dm_write  <= 1'b0;
      dm_read   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      dm_write  <= 1'b0;
      dm_read   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_write <= head_req.write;
            if (head_dec == DEC_ERR) begin
              state <= S_ERR;
            end else begin
              // Address and data only move when a real bus cycle follows.
              dm_addr <= head_req.addr;
              if (head_req.write) begin
                dm_wdata <= head_req.wdata;
                dm_write <= 1'b1;
                state    <= S_WR;
              end else begin
                dm_read <= 1'b1;
                state   <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= dm_rdata;
          state     <= S_IDLE;
        end
        S_WR: begin
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
          state     <= S_IDLE;
        end
        S_ERR: begin
          rsp_valid <= 1'b1;
          rsp_write <= cur_write;
          rsp_err   <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
